// File: rtl/fmdll_delay_ctrl.sv
// fmdll_delay_ctrl: delay-line controller for the FMDLL.
// Runs a SAR coarse search on phase-detector votes, then filtered up/down
// tracking with lock detection. A change of M or N restarts acquisition.
// Optional macro FMDLL_DEADBAND_EN: while locked, a tracking step is applied
// only after two consecutive same-sign window decisions.
//
//   state | meaning
//   IDLE  | code parked at mid-code for one window (held here while N==0)
//   SAR   | binary search, one code bit resolved per window, MSB first
//   TRACK | +/-1 code step per window, lock counter active
module fmdll_delay_ctrl #(
    parameter int CODE_W   = 6,
    parameter int SETTLE   = 4,
    parameter int LOCK_CNT = 8
) (
    input  logic              clk_ext,
    input  logic              rst,
    input  logic              pd_up,
    input  logic              pd_dn,
    input  logic [1:0]        M,
    input  logic [3:0]        N,
    output logic [CODE_W-1:0] code,
    output logic [1:0]        sel,
    output logic              locked,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SAR   = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;

    localparam int WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int VOTE_W = $clog2(SETTLE + 1) + 1;
    localparam int CNT_W  = $clog2(LOCK_CNT + 1);
    localparam int IDX_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    localparam logic [CODE_W-1:0] MID_CODE = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] MAX_CODE = {CODE_W{1'b1}};

    logic [1:0]        state;
    logic [WCNT_W-1:0] wcnt;
    logic [VOTE_W-1:0] vote;
    logic [IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  cnt;
    logic              last_vld;
    logic              last_dir;
    logic [1:0]        m_q;
    logic [3:0]        n_q;
    logic              cfg_vld;
`ifdef FMDLL_DEADBAND_EN
    logic              pend_vld;
    logic              pend_dir;
`endif

    logic              cfg_chg;
    logic              win_end;
    logic [VOTE_W-1:0] cur;
    logic [VOTE_W-1:0] vote_sum;
    logic              dec_up;
    logic              dec_dn;
    logic              step_up;
    logic              step_dn;
    logic [CNT_W-1:0]  cnt_inc;

    // Window bookkeeping, vote decision and the step actually applied in TRACK.
    always_comb begin
        cfg_chg  = cfg_vld && ((M != m_q) || (N != n_q));
        win_end  = (wcnt == WCNT_W'(SETTLE - 1));
        cur      = '0;
        if (pd_up && !pd_dn)
            cur = {{(VOTE_W-1){1'b0}}, 1'b1};
        else if (pd_dn && !pd_up)
            cur = '1;
        vote_sum = vote + cur;
        dec_dn   = vote_sum[VOTE_W-1];
        dec_up   = !vote_sum[VOTE_W-1] && (vote_sum != '0);
        step_up  = dec_up;
        step_dn  = dec_dn;
`ifdef FMDLL_DEADBAND_EN
        if (locked) begin
            step_up = dec_up && pend_vld && pend_dir;
            step_dn = dec_dn && pend_vld && !pend_dir;
        end
`endif
        cnt_inc  = (cnt == CNT_W'(LOCK_CNT)) ? cnt : cnt + CNT_W'(1);
    end

    // Config snapshot for change detection; sel follows M every cycle.
    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            m_q     <= 2'd0;
            n_q     <= 4'd0;
            cfg_vld <= 1'b0;
            sel     <= 2'd0;
        end else begin
            m_q     <= M;
            n_q     <= N;
            cfg_vld <= 1'b1;
            sel     <= (M == 2'd3) ? 2'd2 : ((M == 2'd2) ? 2'd1 : 2'd0);
        end
    end

    // Acquisition/tracking FSM with window counter, vote and lock counter.
    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            vote     <= '0;
            bit_idx  <= IDX_W'(CODE_W - 1);
            cnt      <= '0;
            last_vld <= 1'b0;
            last_dir <= 1'b0;
            code     <= MID_CODE;
            locked   <= 1'b0;
            err      <= 1'b0;
`ifdef FMDLL_DEADBAND_EN
            pend_vld <= 1'b0;
            pend_dir <= 1'b0;
`endif
        end else if (cfg_chg) begin
            state    <= S_IDLE;
            wcnt     <= '0;
            vote     <= '0;
            bit_idx  <= IDX_W'(CODE_W - 1);
            cnt      <= '0;
            last_vld <= 1'b0;
            code     <= MID_CODE;
            locked   <= 1'b0;
            err      <= (N == 4'd0);
`ifdef FMDLL_DEADBAND_EN
            pend_vld <= 1'b0;
`endif
        end else begin
            locked <= (cnt == CNT_W'(LOCK_CNT));
            if (win_end || (state == S_IDLE && N == 4'd0)) begin
                wcnt <= '0;
                vote <= '0;
            end else begin
                wcnt <= wcnt + WCNT_W'(1);
                vote <= vote_sum;
            end
            case (state)
                S_IDLE: begin
                    code     <= MID_CODE;
                    locked   <= 1'b0;
                    cnt      <= '0;
                    last_vld <= 1'b0;
`ifdef FMDLL_DEADBAND_EN
                    pend_vld <= 1'b0;
`endif
                    if (N == 4'd0) begin
                        err <= 1'b1;
                    end else if (win_end) begin
                        state   <= S_SAR;
                        bit_idx <= IDX_W'(CODE_W - 1);
                    end
                end
                S_SAR: begin
                    locked <= 1'b0;
                    if (win_end) begin
                        code[bit_idx] <= dec_up;
                        if (bit_idx != '0) begin
                            code[bit_idx - IDX_W'(1)] <= 1'b1;
                            bit_idx <= bit_idx - IDX_W'(1);
                        end else begin
                            state <= S_TRACK;
                        end
                    end
                end
                S_TRACK: begin
                    if (win_end) begin
                        if (step_up) begin
                            if (code == MAX_CODE) err <= 1'b1;
                            else                  code <= code + CODE_W'(1);
                        end else if (step_dn) begin
                            if (code == '0) err <= 1'b1;
                            else            code <= code - CODE_W'(1);
                        end
                        if (!dec_up && !dec_dn) begin
                            cnt <= cnt_inc;
                        end else if (step_up || step_dn) begin
                            last_vld <= 1'b1;
                            last_dir <= step_up;
                            if (last_vld && (last_dir == step_up)) begin
                                cnt    <= '0;
                                locked <= 1'b0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
`ifdef FMDLL_DEADBAND_EN
                        // A decision that did not step becomes the new pending one.
                        if ((dec_up || dec_dn) && !(step_up || step_dn)) begin
                            pend_vld <= 1'b1;
                            pend_dir <= dec_up;
                        end else begin
                            pend_vld <= 1'b0;
                        end
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
